spi_tx_feeder: RTL and testbench
================================

Name: spi_tx_feeder

Overview:
- Upstream byte buffer and sequencer for the SPI transmitter (spiControlIP).
- Accepts bytes from a producer into a FIFO.
- Presents one byte at a time on the transmitter's spi_data_in and pulses spi_load_data.
- Waits for the transmitter's spi_done_send, then enforces a programmable inter-byte gap before releasing the next byte.

Parameters:
DEPTH, 8, FIFO depth in bytes; power of two, min 2.
GAP_CYCLES, 2, idle clock cycles between done detection and the next load; 0 allowed.
TIMEOUT_CYCLES, 4096, max clock cycles in WAIT_DONE before abort (used only with the optional feature).

Ports:
clock  in  1  system clock (100 MHz).
reset  in  1  asynchronous, active-high reset.
wr_data  in  8  byte to enqueue.
wr_en  in  1  enqueue strobe; accepted when fifo_full=0.
fifo_full  out  1  FIFO holds DEPTH bytes.
fifo_empty  out  1  FIFO holds 0 bytes.
fifo_count  out  $clog2(DEPTH)+1  bytes currently queued.
overflow  out  1  sticky: a write arrived while full.
busy  out  1  high in any state other than IDLE.
spi_data_in  out  8  byte to the transmitter.
spi_load_data  out  1  one-cycle load pulse to the transmitter.
spi_done_send  in  1  completion flag from the transmitter.
timeout_err  out  1  sticky abort flag (optional feature only).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (any time, including mid-byte):
  - All outputs return to their reset values immediately: fifo_count=0, fifo_empty=1, fifo_full=0, overflow=0, busy=0, spi_data_in=8'h00, spi_load_data=0, timeout_err=0.
  - FIFO pointers clear and the FSM goes to IDLE.
  - Queued bytes are discarded.
- FIFO:
  - Circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits; wrap from DEPTH-1 to 0.
  - Count is tracked separately; full is count==DEPTH, empty is count==0.
  - Flags and count are registered and update the cycle after a write or pop.
- Writes:
  - wr_en with fifo_full=0 stores wr_data at the clock edge.
  - wr_en with fifo_full=1 drops the byte and sets overflow; overflow stays set until reset.
  - fifo_full is sampled pre-edge: a write in the same cycle as a pop from a full FIFO is still dropped.
- Write and pop in the same cycle (non-full): both take effect and count is unchanged.
- FSM states:
  - IDLE:
    - If fifo_empty=0, go to LOAD.
  - LOAD (1 cycle):
    - Pop the head byte into spi_data_in, pulse spi_load_data=1, go to WAIT_DONE.
    - spi_data_in holds its value until the next LOAD.
  - WAIT_DONE:
    - Watch for a rising edge of spi_done_send, detected with a one-cycle registered copy of spi_done_send.
    - A level already high on entry is not a completion.
    - On an edge: go to GAP if GAP_CYCLES>0, else go to IDLE.
  - GAP:
    - Down-counter loaded with GAP_CYCLES-1 on entry; go to IDLE when it reaches 0.
    - spi_load_data=0 throughout.
- Latency:
  - wr_en into an empty, idle feeder at edge N → fifo_empty=0 after N → spi_load_data=1 in the cycle after edge N+1.
  - Back-to-back byte spacing: done edge → GAP_CYCLES cycles → 1 IDLE cycle → LOAD.
- spi_load_data is never high for more than one consecutive cycle.
- busy=0 only in IDLE.

Optional Feature:
Macro: SPI_TX_FEEDER_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT_DONE.
  - If it reaches TIMEOUT_CYCLES without a done edge, the FSM goes to IDLE and sets timeout_err; timeout_err stays set until reset.
  - The aborted byte is not retried; remaining FIFO bytes continue to be sent.
- Not defined:
  - timeout_err is tied to 0 and the counter logic is absent.
  - WAIT_DONE waits indefinitely.

Test Plan:
1. DEPTH=8, GAP=2, reset, then write 8'hA5 at edge N (transmitter model raises done 10 cycles after load) → spi_load_data=1 with spi_data_in=A5 in the cycle after N+1, busy=1 until 2 gap cycles after the done edge, then fifo_empty=1 and busy=0.
2. Burst-write 8'h01..8'h08 back to back → fifo_full=1 after 8th write; 9th write 8'hFF is dropped, overflow=1; bytes emitted in order 01..08, FF never appears.
3. Hold spi_done_send high before LOAD, drop it, re-raise it 5 cycles later → only the re-raise completes the byte; no completion at WAIT_DONE entry.
4. GAP_CYCLES=0, two bytes queued → second spi_load_data pulse occurs exactly 2 cycles after the first done rising edge (IDLE, LOAD).
5. Assert reset for 1 cycle while in WAIT_DONE with 3 bytes queued → outputs immediately at reset values, fifo_count=0; no further loads after release without new writes.
6. With SPI_TX_FEEDER_TIMEOUT_EN, TIMEOUT_CYCLES=16, transmitter never signals done, 2 bytes queued → timeout_err=1 after 16 WAIT_DONE cycles, second byte loads next; without the macro the FSM stays in WAIT_DONE.

Source files
------------

// File: rtl/spi_tx_feeder.sv
// spi_tx_feeder: byte FIFO plus load sequencer in front of the SPI transmitter.
// A producer pushes bytes into a circular buffer. The sequencer presents one byte
// at a time on spi_data_in with a one-cycle spi_load_data pulse. It then waits for
// a rising edge of spi_done_send and holds off for GAP_CYCLES idle cycles before it
// releases the next byte.
// Optional feature: define SPI_TX_FEEDER_TIMEOUT_EN to abort a byte whose done edge
// does not arrive within TIMEOUT_CYCLES. The abort sets the sticky timeout_err flag.
module spi_tx_feeder #(
    parameter int DEPTH          = 8,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               wr_data,
    input  logic                     wr_en,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     busy,
    output logic [7:0]               spi_data_in,
    output logic                     spi_load_data,
    input  logic                     spi_done_send,
    output logic                     timeout_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_DONE,
        GAP
    } state_t;

    state_t                 state_reg, state_next;

    logic [7:0]             mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]       count_reg, count_next;
    logic                   full_reg, empty_reg, overflow_reg;
    logic [7:0]             data_reg;
    logic                   done_d_reg;
    logic [GAP_W-1:0]       gap_cnt_reg, gap_cnt_next;
    logic                   do_write, do_pop, done_edge;

`ifdef SPI_TX_FEEDER_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0]        to_cnt_reg, to_cnt_next;
    logic                   timeout_reg, timeout_hit;
`endif

    // The full flag is the registered (pre-edge) one, so a write that meets a pop
    // on a full FIFO is still dropped.
    assign do_write  = wr_en & ~full_reg;
    assign do_pop    = (state_reg == LOAD);
    assign done_edge = spi_done_send & ~done_d_reg;

    // Storage write port; no reset so the array can map onto RAM.
    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Occupancy next value: a simultaneous write and pop cancel out.
    always_comb begin
        count_next = count_reg;
        case ({do_write, do_pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // FIFO pointers, count and registered flags; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (wr_en && full_reg) begin
                overflow_reg <= 1'b1;
            end
            count_reg <= count_next;
            full_reg  <= (count_next == CNT_W'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    // Head byte is read out on the IDLE->LOAD edge, so it is already valid during
    // the LOAD pulse. The pop itself happens when LOAD ends.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_reg <= 8'h00;
        end else if (state_reg == IDLE && !empty_reg) begin
            data_reg <= mem[rd_ptr_reg];
        end
    end

    // Registered copy of the done flag for rising-edge detection. It is updated in
    // every state, so a level that is already high when WAIT_DONE starts is not an edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done_d_reg <= 1'b0;
        end else begin
            done_d_reg <= spi_done_send;
        end
    end

    // Sequencer state and gap counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            gap_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            gap_cnt_reg <= gap_cnt_next;
        end
    end

    // Sequencer next-state logic.
    always_comb begin
        state_next   = state_reg;
        gap_cnt_next = gap_cnt_reg;
`ifdef SPI_TX_FEEDER_TIMEOUT_EN
        to_cnt_next  = to_cnt_reg;
        timeout_hit  = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (!empty_reg) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = WAIT_DONE;
`ifdef SPI_TX_FEEDER_TIMEOUT_EN
                to_cnt_next = '0;
`endif
            end
            WAIT_DONE: begin
                if (done_edge) begin
                    if (GAP_CYCLES > 0) begin
                        state_next   = GAP;
                        gap_cnt_next = GAP_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end
`ifdef SPI_TX_FEEDER_TIMEOUT_EN
                else if (to_cnt_reg == TO_LAST) begin
                    // Abandon this byte; the queue carries on with the next one.
                    state_next  = IDLE;
                    timeout_hit = 1'b1;
                end else begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                end
`endif
            end
            GAP: begin
                if (gap_cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg - GAP_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef SPI_TX_FEEDER_TIMEOUT_EN
    // Wait-cycle counter and sticky abort flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            to_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            to_cnt_reg <= to_cnt_next;
            if (timeout_hit) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_reg;
`else
    assign timeout_err = 1'b0;
`endif

    assign fifo_full     = full_reg;
    assign fifo_empty    = empty_reg;
    assign fifo_count    = count_reg;
    assign overflow      = overflow_reg;
    assign busy          = (state_reg != IDLE);
    assign spi_data_in   = data_reg;
    assign spi_load_data = do_pop;

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Testbench for spi_tx_feeder: a queue/timestamp reference model is checked every
// cycle against the main instance (DEPTH=8, GAP=2). Directed literal checks cover
// each scenario. A second instance with GAP_CYCLES=0 covers the zero-gap spacing.
// The timeout scenario follows SPI_TX_FEEDER_TIMEOUT_EN.
module tb_spi_tx_feeder;

    localparam int DEPTH = 8;
    localparam int GAP   = 2;
    localparam int TMO   = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       spi_done_send = 1'b0;
    logic       fifo_full, fifo_empty, overflow, busy, spi_load_data, timeout_err;
    logic [3:0] fifo_count;
    logic [7:0] spi_data_in;

    logic [7:0] d0_wr_data = 8'h00;
    logic       d0_wr_en = 1'b0;
    logic       d0_done = 1'b0;
    logic       d0_full, d0_empty, d0_overflow, d0_busy, d0_load, d0_timeout;
    logic [2:0] d0_count;
    logic [7:0] d0_data;

    always #5 clk = ~clk;

    spi_tx_feeder #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clk), .reset(rst), .wr_data(wr_data), .wr_en(wr_en),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
        .overflow(overflow), .busy(busy), .spi_data_in(spi_data_in),
        .spi_load_data(spi_load_data), .spi_done_send(spi_done_send),
        .timeout_err(timeout_err)
    );

    spi_tx_feeder #(.DEPTH(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TMO)) dut_g0 (
        .clock(clk), .reset(rst), .wr_data(d0_wr_data), .wr_en(d0_wr_en),
        .fifo_full(d0_full), .fifo_empty(d0_empty), .fifo_count(d0_count),
        .overflow(d0_overflow), .busy(d0_busy), .spi_data_in(d0_data),
        .spi_load_data(d0_load), .spi_done_send(d0_done),
        .timeout_err(d0_timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Cycle index mc; the byte in flight is described by the cycle it loads on and
    // the first cycle at which the feeder is free again.
    logic [7:0] q[$];
    int         mc = 0;
    int         m_load_at = -1;
    int         m_idle_from = 0;
    bit         m_inflight = 0;
    bit         m_over = 0;
    bit         m_tout = 0;
    bit         m_prev_done = 0;
    logic [7:0] m_data = 8'h00;

    initial begin
        int sz;
        bit full_c, load_c, idle_c, edge_c;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                mc = 0; m_load_at = -1; m_idle_from = 0; m_inflight = 0;
                m_over = 0; m_tout = 0; m_prev_done = 0; m_data = 8'h00;
            end else begin
                sz     = q.size();
                full_c = (sz == DEPTH);
                load_c = (mc == m_load_at);
                idle_c = !m_inflight && (mc >= m_idle_from);
                edge_c = spi_done_send && !m_prev_done;
                if (m_inflight && mc > m_load_at) begin
                    if (edge_c) begin
                        m_inflight  = 0;
                        m_idle_from = mc + 1 + GAP;
                    end
`ifdef SPI_TX_FEEDER_TIMEOUT_EN
                    else if (mc - m_load_at == TMO) begin
                        m_inflight  = 0;
                        m_idle_from = mc + 1;
                        m_tout      = 1;
                    end
`endif
                end
                if (idle_c && sz > 0) begin
                    m_load_at  = mc + 1;
                    m_data     = q[0];
                    m_inflight = 1;
                end
                if (load_c) void'(q.pop_front());
                if (wr_en) begin
                    if (full_c) m_over = 1;
                    else q.push_back(wr_data);
                end
                m_prev_done = spi_done_send;
                mc++;
            end
        end
    end

    // Every-cycle comparison of the main instance against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("m_count", 32'(fifo_count), 32'(q.size()));
            chk("m_empty", 32'(fifo_empty), 32'(q.size() == 0));
            chk("m_full", 32'(fifo_full), 32'(q.size() == DEPTH));
            chk("m_overflow", 32'(overflow), 32'(m_over));
            chk("m_load", 32'(spi_load_data), 32'(mc == m_load_at));
            chk("m_busy", 32'(busy), 32'(m_inflight || (mc < m_idle_from)));
            chk("m_data", 32'(spi_data_in), 32'(m_data));
            chk("m_timeout", 32'(timeout_err), 32'(m_tout));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] b);
        wr_en = 1'b1; wr_data = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_load(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (spi_load_data) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_load: no spi_load_data within %0d cycles", budget);
        end
    endtask

    task automatic complete(input int delay);
        tick(delay);
        spi_done_send = 1'b1;
        tick(2);
        spi_done_send = 1'b0;
    endtask

    task automatic serve(input logic [7:0] exp, input string name);
        wait_load(40);
        chk(name, 32'(spi_data_in), 32'(exp));
        complete(3);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int nl;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("rst_count", 32'(fifo_count), 32'h0);
        chk("rst_empty", 32'(fifo_empty), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_data", 32'(spi_data_in), 32'h0);

        // 1: single byte, load latency and gap
        wr_en = 1'b1; wr_data = 8'hA5;
        @(negedge clk);
        wr_en = 1'b0;
        chk("t1_not_empty", 32'(fifo_empty), 32'h0);
        chk("t1_no_early_load", 32'(spi_load_data), 32'h0);
        tick(1);
        chk("t1_load", 32'(spi_load_data), 32'h1);
        chk("t1_data", 32'(spi_data_in), 32'hA5);
        tick(1);
        chk("t1_single_pulse", 32'(spi_load_data), 32'h0);
        tick(9);
        spi_done_send = 1'b1;
        tick(1);
        chk("t1_gap1_busy", 32'(busy), 32'h1);
        tick(1);
        chk("t1_gap2_busy", 32'(busy), 32'h1);
        tick(1);
        chk("t1_idle_busy", 32'(busy), 32'h0);
        chk("t1_idle_empty", 32'(fifo_empty), 32'h1);
        spi_done_send = 1'b0;
        tick(2);

        // 2: burst fill while a primer byte is in flight, overflow on 9th write
        wr(8'h00);
        wait_load(10);
        for (int i = 1; i <= 9; i++) begin
            wr_en = 1'b1;
            wr_data = (i == 9) ? 8'hFF : 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk("t2_full", 32'(fifo_full), 32'h1);
        chk("t2_count", 32'(fifo_count), 32'h8);
        chk("t2_overflow", 32'(overflow), 32'h1);
        complete(3);
        for (int i = 1; i <= 8; i++) serve(8'(i), "t2_order");
        tick(6);
        chk("t2_drained", 32'(fifo_empty), 32'h1);
        chk("t2_overflow_sticky", 32'(overflow), 32'h1);

        // 3: done already high at load is not a completion
        spi_done_send = 1'b1;
        tick(2);
        wr(8'h3C);
        wait_load(10);
        chk("t3_data", 32'(spi_data_in), 32'h3C);
        tick(4);
        chk("t3_no_entry_completion", 32'(busy), 32'h1);
        spi_done_send = 1'b0;
        tick(5);
        spi_done_send = 1'b1;
        tick(2);
        chk("t3_gap_busy", 32'(busy), 32'h1);
        tick(1);
        chk("t3_done_idle", 32'(busy), 32'h0);
        spi_done_send = 1'b0;
        tick(2);

        // 4: zero gap, second load two cycles after the done edge
        d0_wr_en = 1'b1; d0_wr_data = 8'h11;
        @(negedge clk);
        d0_wr_data = 8'h22;
        @(negedge clk);
        d0_wr_en = 1'b0;
        for (int i = 0; i < 20 && !d0_load; i++) @(negedge clk);
        chk("t4_first_load", 32'(d0_load), 32'h1);
        chk("t4_first_data", 32'(d0_data), 32'h11);
        tick(3);
        d0_done = 1'b1;
        tick(1);
        chk("t4_idle_no_load", 32'(d0_load), 32'h0);
        chk("t4_idle_busy", 32'(d0_busy), 32'h0);
        tick(1);
        chk("t4_second_load", 32'(d0_load), 32'h1);
        chk("t4_second_data", 32'(d0_data), 32'h22);
        tick(1);
        d0_done = 1'b0;
        tick(2);
        d0_done = 1'b1;
        tick(2);
        d0_done = 1'b0;
        tick(2);
        chk("t4_drained", 32'(d0_empty), 32'h1);
        chk("t4_idle_end", 32'(d0_busy), 32'h0);

        // 5: asynchronous reset during WAIT_DONE with three bytes queued
        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'h51 + 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk("t5_count_before", 32'(fifo_count), 32'h3);
        chk("t5_busy_before", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_count", 32'(fifo_count), 32'h0);
        chk("t5_rst_empty", 32'(fifo_empty), 32'h1);
        chk("t5_rst_full", 32'(fifo_full), 32'h0);
        chk("t5_rst_overflow", 32'(overflow), 32'h0);
        chk("t5_rst_busy", 32'(busy), 32'h0);
        chk("t5_rst_data", 32'(spi_data_in), 32'h0);
        chk("t5_rst_load", 32'(spi_load_data), 32'h0);
        chk("t5_rst_timeout", 32'(timeout_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        nl = 0;
        repeat (30) begin
            @(negedge clk);
            if (spi_load_data) nl++;
        end
        chk("t5_no_loads", 32'(nl), 32'h0);

        // 6: transmitter never answers
        wr_en = 1'b1; wr_data = 8'hAA;
        @(negedge clk);
        wr_data = 8'hBB;
        @(negedge clk);
        wr_en = 1'b0;
        wait_load(10);
        chk("t6_first_data", 32'(spi_data_in), 32'hAA);
`ifdef SPI_TX_FEEDER_TIMEOUT_EN
        tick(TMO);
        chk("t6_last_wait_busy", 32'(busy), 32'h1);
        chk("t6_no_early_timeout", 32'(timeout_err), 32'h0);
        tick(1);
        chk("t6_timeout", 32'(timeout_err), 32'h1);
        chk("t6_idle", 32'(busy), 32'h0);
        tick(1);
        chk("t6_second_load", 32'(spi_load_data), 32'h1);
        chk("t6_second_data", 32'(spi_data_in), 32'hBB);
        complete(3);
        tick(6);
        chk("t6_timeout_sticky", 32'(timeout_err), 32'h1);
`else
        nl = 0;
        repeat (40) begin
            @(negedge clk);
            if (spi_load_data) nl++;
        end
        chk("t6_stuck_no_load", 32'(nl), 32'h0);
        chk("t6_stuck_busy", 32'(busy), 32'h1);
        chk("t6_stuck_count", 32'(fifo_count), 32'h1);
        chk("t6_no_timeout", 32'(timeout_err), 32'h0);
        complete(1);
        serve(8'hBB, "t6_second_data");
        tick(6);
`endif
        chk("t6_drained", 32'(fifo_empty), 32'h1);
        chk("t6_idle_end", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
